sram_port_arbiter: RTL and testbench

- Shares one single-port, synchronous, 1-cycle-read-latency SRAM between the instruction-fetch port and the load/store port of the 5-stage core.
- Sits between the IF/EX SRAM-like request buses and the physical memory.
- Grants one requester per cycle, routes the read response back to its owner and holds it stable while the owner is stalled.
- Raises a stall request to CTRL whenever a requester is denied.

---
 rtl/sram_port_arbiter.sv | 114 +++++++++++
 tb/tb_sram_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates one 1-cycle-latency single-port SRAM between the fetch and load/store ports.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin conflict resolution instead of data priority plus starvation guard.
module sram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_gnt,
  output logic                  inst_rvalid,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic [DATA_W/8-1:0]   data_wen,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_wen,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  stallreq
);

  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

  owner_t              r_owner;
  logic [DATA_W-1:0]   r_inst_hold;
  logic [DATA_W-1:0]   r_data_hold;
  logic                w_prefer_inst;
  logic                w_inst_gnt;
  logic                w_data_gnt;
  logic                w_conflict;

  assign w_conflict = inst_req & data_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Last conflict winner; resets to inst so data takes the first conflict.
  logic r_last_inst;

  assign w_prefer_inst = ~r_last_inst;

  always_ff @(posedge clk) begin
    if (rst)
      r_last_inst <= 1'b1;
    else if (w_conflict)
      r_last_inst <= w_inst_gnt;
  end
`else
  localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);
  logic [3:0] r_wait_cnt;

  assign w_prefer_inst = (r_wait_cnt == LP_MAX);

  always_ff @(posedge clk) begin
    if (rst)
      r_wait_cnt <= '0;
    else if (!inst_req || w_inst_gnt)
      r_wait_cnt <= '0;
    else if (r_wait_cnt != LP_MAX)
      r_wait_cnt <= r_wait_cnt + 4'd1;
  end
`endif

  assign w_inst_gnt = inst_req & (~data_req | w_prefer_inst);
  assign w_data_gnt = data_req & ~w_inst_gnt;

  assign inst_gnt = w_inst_gnt;
  assign data_gnt = w_data_gnt;
  assign stallreq = (inst_req & ~w_inst_gnt) | (data_req & ~w_data_gnt);
  assign sram_en  = w_inst_gnt | w_data_gnt;

  always_comb begin
    sram_addr  = '0;
    sram_wen   = '0;
    sram_wdata = '0;
    if (w_data_gnt) begin
      sram_addr  = data_addr;
      sram_wen   = data_wen;
      sram_wdata = data_wdata;
    end else if (w_inst_gnt) begin
      sram_addr  = inst_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_NONE;
      r_inst_hold <= '0;
      r_data_hold <= '0;
    end else begin
      if (r_owner == OWN_INST) r_inst_hold <= sram_rdata;
      if (r_owner == OWN_DATA) r_data_hold <= sram_rdata;
      if (w_inst_gnt)
        r_owner <= OWN_INST;
      else if (w_data_gnt && (data_wen == '0))
        r_owner <= OWN_DATA;
      else
        r_owner <= OWN_NONE;
    end
  end

  // A response owed across a reset edge is dropped, including during the reset cycle.
  assign inst_rvalid = (r_owner == OWN_INST) & ~rst;
  assign data_rvalid = (r_owner == OWN_DATA) & ~rst;
  assign inst_rdata  = inst_rvalid ? sram_rdata : r_inst_hold;
  assign data_rdata  = data_rvalid ? sram_rdata : r_data_hold;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a small behavioural SRAM.
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        stallreq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .stallreq(stallreq)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_rd = 32'h2408_0001;
      32'h0000_2000: mem_rd = 32'hCAFE_0002;
      default:       mem_rd = a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  always @(posedge clk)
    if (sram_en && sram_wen == 4'b0000) sram_rdata <= mem_rd(sram_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wen = '0; data_addr = '0; data_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    step(); step();
    rst = 0;
    @(negedge clk);
    tests++; if (inst_rvalid !== 1'b0) begin fails++; $display("FAIL rst_inst_rvalid got %b exp 0", inst_rvalid); end
    tests++; if (data_rvalid !== 1'b0) begin fails++; $display("FAIL rst_data_rvalid got %b exp 0", data_rvalid); end
    tests++; if (inst_rdata !== 32'h0) begin fails++; $display("FAIL rst_inst_rdata got %h exp 0", inst_rdata); end
    tests++; if (data_rdata !== 32'h0) begin fails++; $display("FAIL rst_data_rdata got %h exp 0", data_rdata); end
    tests++; if ({sram_en, stallreq} !== 2'b00) begin fails++; $display("FAIL rst_idle en/stall got %b exp 00", {sram_en, stallreq}); end
  endtask

  task automatic test_inst_read();
    step();
    inst_req = 1; inst_addr = 32'h100;
    @(negedge clk);
    tests++; if (inst_gnt !== 1'b1) begin fails++; $display("FAIL ird_gnt got %b exp 1", inst_gnt); end
    tests++; if (sram_addr !== 32'h100) begin fails++; $display("FAIL ird_addr got %h exp 00000100", sram_addr); end
    tests++; if ({sram_en, sram_wen, stallreq} !== 6'b1_0000_0) begin fails++; $display("FAIL ird_en/wen/stall got %b exp 100000", {sram_en, sram_wen, stallreq}); end
    step();
    idle();
    @(negedge clk);
    tests++; if (inst_rvalid !== 1'b1) begin fails++; $display("FAIL ird_rvalid got %b exp 1", inst_rvalid); end
    tests++; if (inst_rdata !== 32'h2408_0001) begin fails++; $display("FAIL ird_rdata got %h exp 24080001", inst_rdata); end
    step();
    @(negedge clk);
    tests++; if (inst_rvalid !== 1'b0) begin fails++; $display("FAIL ird_rvalid2 got %b exp 0", inst_rvalid); end
    tests++; if (inst_rdata !== 32'h2408_0001) begin fails++; $display("FAIL ird_hold got %h exp 24080001", inst_rdata); end
  endtask

  task automatic test_conflict();
    step();
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wen = 4'b0000; data_addr = 32'h2000;
    @(negedge clk);
    tests++; if ({data_gnt, inst_gnt, stallreq} !== 3'b101) begin fails++; $display("FAIL cf_gnt d/i/stall got %b exp 101", {data_gnt, inst_gnt, stallreq}); end
    tests++; if (sram_addr !== 32'h2000) begin fails++; $display("FAIL cf_addr got %h exp 00002000", sram_addr); end
    step();
    data_req = 0;
    @(negedge clk);
    tests++; if ({inst_gnt, data_rvalid, inst_rvalid} !== 3'b110) begin fails++; $display("FAIL cf_b2b ig/drv/irv got %b exp 110", {inst_gnt, data_rvalid, inst_rvalid}); end
    tests++; if (data_rdata !== 32'hCAFE_0002) begin fails++; $display("FAIL cf_drdata got %h exp cafe0002", data_rdata); end
    step();
    idle();
    @(negedge clk);
    tests++; if ({inst_rvalid, data_rvalid} !== 2'b10) begin fails++; $display("FAIL cf_resp2 irv/drv got %b exp 10", {inst_rvalid, data_rvalid}); end
    tests++; if (inst_rdata !== 32'h2408_0001) begin fails++; $display("FAIL cf_irdata got %h exp 24080001", inst_rdata); end
    tests++; if (data_rdata !== 32'hCAFE_0002) begin fails++; $display("FAIL cf_dhold got %h exp cafe0002", data_rdata); end
  endtask

  task automatic test_write();
    step();
    data_req = 1; data_wen = 4'b0011; data_addr = 32'h3000; data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++; if (data_gnt !== 1'b1) begin fails++; $display("FAIL wr_gnt got %b exp 1", data_gnt); end
    tests++; if (sram_wen !== 4'b0011) begin fails++; $display("FAIL wr_wen got %b exp 0011", sram_wen); end
    tests++; if (sram_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_wdata got %h exp deadbeef", sram_wdata); end
    tests++; if (sram_addr !== 32'h3000) begin fails++; $display("FAIL wr_addr got %h exp 00003000", sram_addr); end
    step();
    idle();
    @(negedge clk);
    tests++; if (data_rvalid !== 1'b0) begin fails++; $display("FAIL wr_rvalid got %b exp 0", data_rvalid); end
    tests++; if (data_rdata !== 32'hCAFE_0002) begin fails++; $display("FAIL wr_dhold got %h exp cafe0002", data_rdata); end
    tests++; if ({sram_en, sram_wdata} !== 33'h0) begin fails++; $display("FAIL wr_idle en/wdata got %h exp 0", {sram_en, sram_wdata}); end
  endtask

  task automatic test_reset_mid();
    step();
    inst_req = 1; inst_addr = 32'h400;
    @(negedge clk);
    tests++; if (inst_gnt !== 1'b1) begin fails++; $display("FAIL rm_gnt got %b exp 1", inst_gnt); end
    step();
    idle(); rst = 1;
    step();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin fails++; $display("FAIL rm_rvalid c%0d got %b exp 00", c, {inst_rvalid, data_rvalid}); end
      tests++; if ({inst_rdata, data_rdata} !== 64'h0) begin fails++; $display("FAIL rm_rdata c%0d got %h exp 0", c, {inst_rdata, data_rdata}); end
      step();
    end
  endtask

`ifndef ARB_ROUND_ROBIN_EN
  task automatic test_starvation();
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wen = 4'b0000; data_addr = 32'h2000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if ({inst_gnt, data_gnt, stallreq} !== {(c == 4), (c != 4), 1'b1}) begin
        fails++;
        $display("FAIL starve c%0d i/d/stall got %b exp %b", c, {inst_gnt, data_gnt, stallreq}, {(c == 4), (c != 4), 1'b1});
      end
      step();
    end
    idle();
    step();
  endtask
`else
  task automatic test_round_robin();
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wen = 4'b0000; data_addr = 32'h2000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if ({inst_gnt, data_gnt, stallreq} !== {(c % 2 == 1), (c % 2 == 0), 1'b1}) begin
        fails++;
        $display("FAIL rr c%0d i/d/stall got %b exp %b", c, {inst_gnt, data_gnt, stallreq}, {(c % 2 == 1), (c % 2 == 0), 1'b1});
      end
      step();
    end
    idle();
    step();
  endtask
`endif

  initial begin
    rst = 1; idle();
    test_reset();
    test_inst_read();
    test_conflict();
    test_write();
    test_reset_mid();
`ifndef ARB_ROUND_ROBIN_EN
    test_starvation();
`else
    test_round_robin();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
